// File: rtl/mc_controller_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// variable-latency memory.
interface mc_controller_if;
   logic mem_req;
   logic mem_write;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_write,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_write,
      output mem_ready
   );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// with memory timeout, sticky trap on illegal opcodes and a retired counter.
module mc_controller #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   mc_controller_if.master  mem,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic [3:0]       state,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_I_EXEC    = 4'd9,
      S_I_WB      = 4'd10,
      S_JUMP      = 4'd11,
      S_JAL       = 4'd12,
      S_TRAP      = 4'd13
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_AND   = 3'd2,
      ALU_OR    = 3'd3,
      ALU_XOR   = 3'd4,
      ALU_LUI   = 3'd5,
      ALU_FUNCT = 3'd7
   } alu_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam int unsigned        WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(TIMEOUT);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               trap_q, trap_d;
   logic [1:0]         cause_q, cause_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   logic       mem_req_c, mem_write_c, iord_c, ir_write_c, pc_write_c;
   logic [1:0] pc_src_c, alu_src_b_c, reg_dst_c, mem_to_reg_c;
   logic       alu_src_a_c, reg_write_c;
   alu_e       alu_op_c;
   logic       retire, mem_wait;

   always_comb begin
      mem_req_c    = 1'b0;
      mem_write_c  = 1'b0;
      iord_c       = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      pc_src_c     = 2'd0;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = 2'd0;
      alu_op_c     = ALU_ADD;
      reg_write_c  = 1'b0;
      reg_dst_c    = 2'd0;
      mem_to_reg_c = 2'd0;
      state_d      = state_q;
      wait_d       = '0;
      trap_d       = trap_q;
      cause_d      = cause_q;
      retired_d    = retired_q;
      retire       = 1'b0;
      mem_wait     = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req_c   = 1'b1;
            alu_src_b_c = 2'd1;
            if (mem.mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end else begin
               mem_wait = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b_c = 2'd3;
            case (opcode)
               OP_RTYPE:                                  state_d = (funct == FN_JR) ? S_JUMP : S_R_EXEC;
               OP_LW, OP_SW:                              state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_I_EXEC;
               OP_J:                                      state_d = S_JUMP;
               OP_JAL:                                    state_d = S_JAL;
               default: begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'd1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
            state_d     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            if (mem.mem_ready) state_d  = S_MEM_WB;
            else               mem_wait = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 2'd1;
            retire       = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req_c   = 1'b1;
            mem_write_c = 1'b1;
            iord_c      = 1'b1;
            if (mem.mem_ready) retire   = 1'b1;
            else               mem_wait = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = ALU_FUNCT;
            state_d     = S_R_WB;
         end
         S_R_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 2'd1;
            retire      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = ALU_SUB;
            pc_src_c    = 2'd1;
            pc_write_c  = (opcode == OP_BNE) ? ~zero : zero;
            retire      = 1'b1;
         end
         S_I_EXEC: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
            case (opcode)
               OP_ANDI: alu_op_c = ALU_AND;
               OP_ORI:  alu_op_c = ALU_OR;
               OP_XORI: alu_op_c = ALU_XOR;
               OP_LUI:  alu_op_c = ALU_LUI;
               default: alu_op_c = ALU_ADD;
            endcase
            state_d = S_I_WB;
         end
         S_I_WB: begin
            reg_write_c = 1'b1;
            retire      = 1'b1;
         end
         S_JUMP: begin
            pc_write_c = 1'b1;
            pc_src_c   = (opcode == OP_RTYPE) ? 2'd3 : 2'd2;
            retire     = 1'b1;
         end
         S_JAL: begin
            pc_write_c   = 1'b1;
            pc_src_c     = 2'd2;
            reg_write_c  = 1'b1;
            reg_dst_c    = 2'd2;
            mem_to_reg_c = 2'd2;
            retire       = 1'b1;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase

      if (retire) begin
         state_d   = S_FETCH;
         retired_d = retired_q + 1'b1;
      end

      // wait_d stays '0 on any state change, so every memory state is entered with a clear count
      if (mem_wait) begin
         if ((TIMEOUT != 0) && (wait_q == WAIT_MAX)) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd2;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         trap_q    <= 1'b0;
         cause_q   <= 2'd0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
         retired_q <= retired_d;
      end
   end

   assign mem.mem_req   = rst ? 1'b0 : mem_req_c;
   assign mem.mem_write = rst ? 1'b0 : mem_write_c;
   assign iord          = rst ? 1'b0 : iord_c;
   assign ir_write      = rst ? 1'b0 : ir_write_c;
   assign pc_write      = rst ? 1'b0 : pc_write_c;
   assign pc_src        = rst ? '0   : pc_src_c;
   assign alu_src_a     = rst ? 1'b0 : alu_src_a_c;
   assign alu_src_b     = rst ? '0   : alu_src_b_c;
   assign alu_op        = rst ? '0   : alu_op_c;
   assign reg_write     = rst ? 1'b0 : reg_write_c;
   assign reg_dst       = rst ? '0   : reg_dst_c;
   assign mem_to_reg    = rst ? '0   : mem_to_reg_c;
   assign state         = state_q;
   assign trap          = trap_q;
   assign trap_cause    = cause_q;
   assign retired       = retired_q;

endmodule
